// File: rtl/subsurf_pkg.sv
// subsurf_pkg: constants and reader FSM state shared by the subsurf RAM readers.
package subsurf_pkg;
   localparam int ADDR_WIDTH = 9;
   localparam logic [3:0] RAM_WE_NONE = 4'b0;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} reader_state_t;
endpackage

// File: rtl/reader_fifo2.sv
// reader_fifo2: 2-entry FIFO holding {last, data} words returned from the RES RAM.
module reader_fifo2 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  logic [32:0] din_i,
   input  logic        pop_i,
   output logic [32:0] dout_o,
   output logic        full_o,
   output logic        empty_o,
   output logic [1:0]  count_o
);
   logic [32:0] mem_q [2];
   logic        wp_q, rp_q;
   logic [1:0]  cnt_q, cnt_d;
   assign cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wp_q     <= 1'b0;
         rp_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wp_q] <= din_i;
            wp_q        <= ~wp_q;
         end
         if (pop_i) rp_q <= ~rp_q;
         cnt_q <= cnt_d;
      end
   end
   assign dout_o  = mem_q[rp_q];
   assign full_o  = cnt_q == 2'd2;
   assign empty_o = cnt_q == 2'd0;
   assign count_o = cnt_q;
endmodule

// File: rtl/result_reader.sv
// result_reader: drains a finished mesh from the RES RAM onto a valid/ready stream.
// Defining RESULT_READER_CHECKSUM_EN adds a running checksum of accepted words.
module result_reader #(
   parameter int ADDR_WIDTH = subsurf_pkg::ADDR_WIDTH,
   parameter int BASE_ADDR  = 0,
   parameter int DEPTH      = 512
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [31:0]           word_count,
   output logic                  ram_en,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic [3:0]            ram_we,
   output logic [31:0]           ram_di,
   input  logic [31:0]           ram_do,
   output logic                  out_valid,
   output logic [31:0]           out_data,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
`ifdef RESULT_READER_CHECKSUM_EN
   ,
   output logic [31:0]           checksum
`endif
);
   import subsurf_pkg::*;
   reader_state_t state_q, state_d;
   logic [31:0] n_q, n_d, iss_q, iss_d, acc_q, acc_d;
   logic        inf_q, inf_last_q;
   logic        accept, issue, fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [1:0]  fifo_cnt;
   logic [32:0] fifo_dout;
   assign ram_we = RAM_WE_NONE;
   assign ram_di = '0;
   assign accept = out_valid && out_ready;
   // A word leaving this cycle frees its slot, which keeps the stream bubble-free.
   assign issue  = state_q == FETCH && ({1'b0, fifo_cnt} + {2'b0, inf_q} - {2'b0, accept}) < 3'd2;
   assign ram_en = issue;
   assign ram_a  = ADDR_WIDTH'(BASE_ADDR + iss_q);
   assign out_valid = !fifo_empty || inf_q;
   assign {out_last, out_data} = !fifo_empty ? fifo_dout : inf_q ? {inf_last_q, ram_do} : 33'b0;
   assign fifo_pop  = accept && !fifo_empty;
   assign fifo_push = inf_q && !(fifo_empty && accept) && (!fifo_full || fifo_pop);
   assign busy = state_q != IDLE;
   assign done = state_q == FIN;
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      iss_d   = iss_q + {31'b0, issue};
      acc_d   = acc_q + {31'b0, accept};
      if (state_q == IDLE && start) begin
         n_d     = word_count > 32'(DEPTH) ? 32'(DEPTH) : word_count;
         iss_d   = '0;
         acc_d   = '0;
         state_d = n_d == '0 ? DRAIN : FETCH;
      end else if ((state_q == FETCH || state_q == DRAIN) && acc_d == n_q)
         state_d = FIN;
      else if (state_q == FETCH && iss_d == n_q)
         state_d = DRAIN;
      else if (state_q == FIN)
         state_d = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         n_q        <= '0;
         iss_q      <= '0;
         acc_q      <= '0;
         inf_q      <= 1'b0;
         inf_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         iss_q      <= iss_d;
         acc_q      <= acc_d;
         inf_q      <= issue;
         inf_last_q <= issue && iss_q == n_q - 32'd1;
      end
   end
   reader_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .din_i   ({inf_last_q, ram_do}),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );
`ifdef RESULT_READER_CHECKSUM_EN
   logic [31:0] checksum_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) checksum_q <= '0;
      else if (state_q == IDLE && start) checksum_q <= '0;
      else if (accept) checksum_q <= checksum_q + out_data;
   end
   assign checksum = checksum_q;
`endif
endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: table-driven transfers of result_reader against a preloaded RES RAM model.
module tb_result_reader;
   localparam int AW = 9, BASE = 500, DEPTH = 512;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
   logic [31:0] word_count = '0, ram_do = '0;
   logic ram_en, out_valid, out_last, busy, done;
   logic [AW-1:0] ram_a;
   logic [3:0] ram_we;
   logic [31:0] ram_di, out_data;
`ifdef RESULT_READER_CHECKSUM_EN
   logic [31:0] checksum;
`endif
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;

   result_reader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
      .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .done(done)
`ifdef RESULT_READER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   // word k of the mesh lives at address (BASE + k) mod 512 and holds 0xA000_0000 + k
   always @(posedge clk) if (ram_en) ram_do <= 32'hA000_0000 + 32'((int'(ram_a) + DEPTH - BASE) % DEPTH);

   int cur_n, iss, acc, t0, cyc = 0, done_cnt, busy_cyc, val_cyc, first_en, first_val, done_rel;
   int addr_bad, data_bad, last_bad, hold_bad, occ_bad;
   logic stall_q;
   logic [32:0] held;

   always @(negedge clk) begin
      cyc++;
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; done_rel = cyc - t0; end
      if (ram_en) begin
         if (first_en < 0) first_en = cyc - t0;
         if (32'(ram_a) != 32'((BASE + iss) % 512)) addr_bad++;
         if (iss - acc - int'(out_valid && out_ready) >= 2) occ_bad++;
         iss++;
      end
      if (out_valid) begin
         if (first_val < 0) first_val = cyc - t0;
         val_cyc++;
         if (stall_q && {out_last, out_data} != held) hold_bad++;
      end
      if (out_valid && out_ready) begin
         if (out_data != 32'hA000_0000 + 32'(acc)) data_bad++;
         if (out_last != (acc == cur_n - 1)) last_bad++;
         acc++;
      end
      stall_q = out_valid && !out_ready;
      held = {out_last, out_data};
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon(input int n);
      cur_n = n; iss = 0; acc = 0; done_cnt = 0; busy_cyc = 0; val_cyc = 0;
      first_en = -1; first_val = -1; done_rel = -1;
      addr_bad = 0; data_bad = 0; last_bad = 0; hold_bad = 0; occ_bad = 0;
      stall_q = 1'b0;
   endtask

   typedef struct { logic [31:0] wc; logic [3:0] pat; int restart; int exp_n; } vec_t;
   vec_t vecs[6];

   task automatic run(input vec_t v);
      clear_mon(v.exp_n);
      word_count = v.wc;
      start = 1'b1;
      out_ready = v.pat[0];
      @(posedge clk); #1;
      start = 1'b0;
      t0 = cyc;
      for (int c = 1; c < 2000 && done_cnt == 0; c++) begin
         out_ready = v.pat[c % 4];
         start = (c == v.restart);
         @(posedge clk); #1;
      end
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      chk({tag, "_accepted"}, acc, v.exp_n);
      chk({tag, "_issued"}, iss, v.exp_n);
      chk({tag, "_addr_errs"}, addr_bad, 0);
      chk({tag, "_data_errs"}, data_bad, 0);
      chk({tag, "_last_errs"}, last_bad, 0);
      chk({tag, "_hold_errs"}, hold_bad, 0);
      chk({tag, "_slot_errs"}, occ_bad, 0);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_busy_after"}, busy, 0);
      if (v.pat == 4'b1111) begin
         chk({tag, "_done_cycle"}, done_rel, v.exp_n + 2);
         chk({tag, "_busy_cycles"}, busy_cyc, v.exp_n + 2);
         if (v.exp_n > 0) begin
            chk({tag, "_first_en"}, first_en, 1);
            chk({tag, "_first_valid"}, first_val, 2);
         end else begin
            chk({tag, "_ram_en_cnt"}, iss, 0);
            chk({tag, "_valid_cycles"}, val_cyc, 0);
         end
      end
   endtask

   initial begin
      vecs[0] = '{32'd3,   4'b1111, -1, 3};
      vecs[1] = '{32'd5,   4'b1001, -1, 5};
      vecs[2] = '{32'd0,   4'b1111, -1, 0};
      vecs[3] = '{32'd700, 4'b1111, -1, 512};
      vecs[4] = '{32'd4,   4'b1111,  2, 4};
      vecs[5] = '{32'd1,   4'b0110, -1, 1};
      clear_mon(0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {busy, done, out_valid, out_last, ram_en}, 0);
      chk("reset_data", out_data, 0);
      chk("ram_we_ram_di", {ram_we, ram_di}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) check_vec_run(i);
      // reset while stalled in DRAIN with both FIFO slots full
      clear_mon(2);
      word_count = 32'd2;
      start = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("stalled_valid", out_valid, 1);
      chk("stalled_data", out_data, 32'hA000_0000);
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {busy, done, out_valid, out_last, ram_en}, 0);
      chk("midreset_data", out_data, 0);
      repeat (3) begin @(posedge clk); #1; end
      chk("midreset_no_done", done_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run('{32'd2, 4'b1111, -1, 2});
      check_vec("after_reset", '{32'd2, 4'b1111, -1, 2});
`ifdef RESULT_READER_CHECKSUM_EN
      chk("checksum", checksum, 32'h4000_0001);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   task automatic check_vec_run(input int i);
      run(vecs[i]);
      check_vec($sformatf("v%0d", i), vecs[i]);
   endtask
endmodule
